// File: rtl/vend_io_pkg.sv
// Shared types and constants for the vending machine board I/O blocks.
package vend_io_pkg;

   typedef enum logic [1:0] {
      PD_IDLE,
      PD_ON,
      PD_GAP
   } pd_state_t;

   localparam int MS_50M = 50_000;

endpackage

// File: rtl/pulse_driver_if.sv
// Event strobe in, pulse outputs back; master is the FSM side, slave is the driver.
interface pulse_driver_if #(
   parameter int PEND_W = 3
);
   logic              EVT;
   logic              Y;
   logic              BUSY;
   logic [PEND_W-1:0] PENDING;
   logic              OVF;

   modport master (
      output EVT,
      input  Y,
      input  BUSY,
      input  PENDING,
      input  OVF
   );

   modport slave (
      input  EVT,
      output Y,
      output BUSY,
      output PENDING,
      output OVF
   );
endinterface

// File: rtl/pulse_driver_ms_timer.sv
// Millisecond delay timer: a cycle prescaler feeding a ms counter, with done
// asserted on the last cycle of a target-ms interval measured from restart.
module ms_timer
   import vend_io_pkg::*;
#(
   parameter int CLK_PER_MS = MS_50M,
   parameter int TGT_W      = 8
) (
   input  logic             CLK50M,
   input  logic             RESET,
   input  logic             restart,
   input  logic [TGT_W-1:0] target,
   output logic             done
);

   localparam int CYC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [TGT_W-1:0] ms_q, ms_d;
   logic             ms_tick;

   always_comb begin
      ms_tick = (cyc_q == CYC_W'(CLK_PER_MS - 1));
      done    = ms_tick && (ms_q == target - TGT_W'(1));
      cyc_d   = ms_tick ? '0 : cyc_q + CYC_W'(1);
      ms_d    = ms_tick ? ms_q + TGT_W'(1) : ms_q;
      // Restart wins so the next interval begins counting from zero
      if (restart) begin
         cyc_d = '0;
         ms_d  = '0;
      end
   end

   always_ff @(posedge CLK50M or posedge RESET) begin
      if (RESET) begin
         cyc_q <= '0;
         ms_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         ms_q  <= ms_d;
      end
   end

endmodule

// File: rtl/pulse_driver.sv
// Stretches single-cycle event strobes into fixed-length output pulses with a
// minimum low gap, queueing back-to-back events in a saturating counter.
module pulse_driver
   import vend_io_pkg::*;
#(
   parameter int CLK_PER_MS = MS_50M,
   parameter int ON_MS      = 200,
   parameter int OFF_MS     = 100,
   parameter int PEND_W     = 3
) (
   input  logic         CLK50M,
   input  logic         RESET,
   pulse_driver_if.slave bus
);

   localparam int MAX_MS = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
   localparam int TGT_W  = $clog2(MAX_MS + 1);

   pd_state_t         state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              y_q, y_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;

   logic             done;
   logic             restart;
   logic [TGT_W-1:0] target;
   logic             inc;
   logic             dec;

   // Holding restart through IDLE guarantees a fresh interval on every entry
   assign restart = (state_q == PD_IDLE) || done;
   assign target  = (state_q == PD_GAP) ? TGT_W'(OFF_MS) : TGT_W'(ON_MS);

   ms_timer #(
      .CLK_PER_MS(CLK_PER_MS),
      .TGT_W     (TGT_W)
   ) u_timer (
      .CLK50M (CLK50M),
      .RESET  (RESET),
      .restart(restart),
      .target (target),
      .done   (done)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      ovf_d   = 1'b0;
      inc     = 1'b0;
      dec     = 1'b0;

      case (state_q)
         PD_IDLE: begin
            if (bus.EVT) state_d = PD_ON;
         end
         PD_ON: begin
            inc = bus.EVT;
            if (done) state_d = PD_GAP;
         end
         PD_GAP: begin
            if (done) begin
               if (pend_q != '0) begin
                  state_d = PD_ON;
                  dec     = 1'b1;
                  inc     = bus.EVT;
               end else if (bus.EVT) begin
                  // Event starts the next pulse directly, bypassing the queue
                  state_d = PD_ON;
               end else begin
                  state_d = PD_IDLE;
               end
            end else begin
               inc = bus.EVT;
            end
         end
         default: state_d = PD_IDLE;
      endcase

      if (dec && !inc) begin
         pend_d = pend_q - PEND_W'(1);
      end else if (inc && !dec) begin
         if (pend_q == {PEND_W{1'b1}}) ovf_d = 1'b1;
         else                          pend_d = pend_q + PEND_W'(1);
      end

      y_d    = (state_d == PD_ON);
      busy_d = (state_d != PD_IDLE);
   end

   always_ff @(posedge CLK50M or posedge RESET) begin
      if (RESET) begin
         state_q <= PD_IDLE;
         pend_q  <= '0;
         y_q     <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.Y       = y_q;
   assign bus.BUSY    = busy_q;
   assign bus.PENDING = pend_q;
   assign bus.OVF     = ovf_q;

endmodule

// File: tb/tb_pulse_driver.sv
// Directed bench for pulse_driver with a 4-cycle ms, 3 ms on, 2 ms gap, 2-bit queue.
module tb_pulse_driver;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;
   string scenario;

   bit evtA  [0:127];
   int expY  [0:127];
   int expB  [0:127];
   int expP  [0:127];
   int expO  [0:127];

   pulse_driver_if #(.PEND_W(2)) bus ();

   pulse_driver #(
      .CLK_PER_MS(4),
      .ON_MS     (3),
      .OFF_MS    (2),
      .PEND_W    (2)
   ) dut (
      .CLK50M(clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int obs, input int exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " Y"}, int'(bus.Y), 0);
      checkOutput({tag, " BUSY"}, int'(bus.BUSY), 0);
      checkOutput({tag, " PENDING"}, int'(bus.PENDING), 0);
      checkOutput({tag, " OVF"}, int'(bus.OVF), 0);
   endtask

   task automatic clearExp();
      for (int i = 0; i < 128; i++) begin
         evtA[i] = 1'b0;
         expY[i] = 0;
         expB[i] = 0;
         expP[i] = 0;
         expO[i] = 0;
      end
   endtask

   task automatic setY(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) expY[i] = 1;
   endtask

   task automatic setB(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) expB[i] = 1;
   endtask

   task automatic setP(input int lo, input int hi, input int v);
      for (int i = lo; i <= hi; i++) expP[i] = v;
   endtask

   task automatic doReset();
      rst     = 1'b1;
      bus.EVT = 1'b0;
      tick();
      tick();
      checkAllZero({scenario, " in reset"});
      rst = 1'b0;
   endtask

   // evtA[c] drives EVT during cycle c; outputs are checked just after each edge
   task automatic applyStimulus(input int ncyc);
      for (int c = 1; c <= ncyc; c++) begin
         bus.EVT = evtA[c-1];
         tick();
         bus.EVT = 1'b0;
         checkOutput($sformatf("%s Y@%0d", scenario, c), int'(bus.Y), expY[c]);
         checkOutput($sformatf("%s BUSY@%0d", scenario, c), int'(bus.BUSY), expB[c]);
         checkOutput($sformatf("%s PENDING@%0d", scenario, c), int'(bus.PENDING), expP[c]);
         checkOutput($sformatf("%s OVF@%0d", scenario, c), int'(bus.OVF), expO[c]);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst         = 1'b1;
      bus.EVT     = 1'b0;
      #2;
      checkAllZero("power-on reset");

      scenario = "single";
      clearExp();
      evtA[10] = 1'b1;
      setY(11, 22);
      setB(11, 30);
      doReset();
      applyStimulus(36);

      scenario = "two";
      clearExp();
      evtA[10] = 1'b1;
      evtA[15] = 1'b1;
      setY(11, 22);
      setY(31, 42);
      setB(11, 50);
      setP(16, 30, 1);
      doReset();
      applyStimulus(55);

      scenario = "overflow";
      clearExp();
      evtA[10] = 1'b1;
      for (int i = 12; i <= 16; i++) evtA[i] = 1'b1;
      setY(11, 22);
      setY(31, 42);
      setY(51, 62);
      setY(71, 82);
      setB(11, 90);
      setP(13, 13, 1);
      setP(14, 14, 2);
      setP(15, 30, 3);
      setP(31, 50, 2);
      setP(51, 70, 1);
      expO[16] = 1;
      expO[17] = 1;
      doReset();
      applyStimulus(100);

      scenario = "gapdone-direct";
      clearExp();
      evtA[10] = 1'b1;
      evtA[30] = 1'b1;
      setY(11, 22);
      setY(31, 42);
      setB(11, 50);
      doReset();
      applyStimulus(55);

      scenario = "gapdone-pend";
      clearExp();
      evtA[10] = 1'b1;
      evtA[15] = 1'b1;
      evtA[30] = 1'b1;
      setY(11, 22);
      setY(31, 42);
      setY(51, 62);
      setB(11, 70);
      setP(16, 50, 1);
      doReset();
      applyStimulus(75);

      scenario = "midreset";
      clearExp();
      evtA[10] = 1'b1;
      evtA[12] = 1'b1;
      evtA[15] = 1'b1;
      setY(11, 17);
      setB(11, 17);
      setP(13, 15, 1);
      setP(16, 17, 2);
      doReset();
      applyStimulus(17);
      rst = 1'b1;
      #1;
      checkAllZero("midreset async");
      tick();
      tick();
      rst = 1'b0;
      scenario = "post-reset idle";
      clearExp();
      applyStimulus(30);
      scenario = "post-reset evt";
      clearExp();
      evtA[5] = 1'b1;
      setY(6, 17);
      setB(6, 25);
      applyStimulus(30);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pulse_driver.md
Name: pulse_driver

Overview:
- Output-side counterpart of the input conditioning: turns single-cycle event strobes from the vending FSM into timed, human/actuator-visible pulses (LED, buzzer, coin-return solenoid).
- Guarantees a fixed on-time and a minimum off-gap between pulses.
- Buffers back-to-back events in a saturating pending counter so no strobe is lost until the counter saturates.
- Sits between the vending FSM and board output pins, on the CLK50M domain.

Parameters:
CLK_PER_MS, 50_000, CLK50M cycles per millisecond (1 ms at 50 MHz).
ON_MS, 200, pulse high time in ms (>=1).
OFF_MS, 100, minimum low gap after each pulse in ms (>=1).
PEND_W, 3, width of the pending-event counter; maximum pending = 2**PEND_W-1.

Ports:
CLK50M  input  1  system clock, 50 MHz.
RESET  input  1  asynchronous, active-high reset.
EVT  input  1  event strobe from the FSM, synchronous to CLK50M; every high cycle is one event.
Y  output  1  registered physical output; high during a pulse.
BUSY  output  1  high in ON or GAP state.
PENDING  output  PEND_W  events accepted but not yet started.
OVF  output  1  one-cycle pulse when an event is dropped because PENDING is saturated.

Behaviour:
- Reset (asynchronous, RESET=1):
  - State=IDLE; Y=0, BUSY=0, PENDING=0, OVF=0.
  - Timer cleared.
  - A pulse in progress is cut immediately and is not resumed after reset releases.
- States:
  - IDLE: Y=0, BUSY=0.
  - ON: Y=1, BUSY=1.
  - GAP: Y=0, BUSY=1.
- Timer:
  - Cycle counter wraps at CLK_PER_MS-1 and produces ms_tick.
  - A ms counter counts those ticks.
  - Both restart to 0 on every state entry.
  - Done fires on the cycle the ms count reaches the target with ms_tick.
  - ON lasts exactly ON_MS*CLK_PER_MS cycles; GAP lasts exactly OFF_MS*CLK_PER_MS cycles.
  - Counter widths are sized with $clog2 from the parameters; no truncation.
- Transitions:
  - IDLE, EVT=1: go to ON. Y rises the cycle after the EVT cycle (1-cycle latency). PENDING unchanged.
  - ON, done: go to GAP.
  - GAP, done, PENDING>0: go to ON and decrement PENDING.
  - GAP, done, PENDING=0, EVT=1: go to ON. The event is consumed directly and PENDING is not touched.
  - GAP, done, PENDING=0, EVT=0: go to IDLE.
- Event acceptance while BUSY (outside the consume case above): EVT increments PENDING.
- Simultaneous increment and decrement (GAP done with PENDING>0 and EVT=1): PENDING stays the same.
- Saturation:
  - EVT while PENDING=2**PEND_W-1 with no decrement that cycle: event dropped, OVF=1 for exactly one cycle, PENDING held.
  - With a simultaneous decrement, the event is accepted and no OVF.
- Sustained EVT high: treated as one event per cycle; upstream drives single-cycle strobes.
- Y is driven directly from a flop; there is no combinational path from EVT to Y.

Decomposition:
- Shared package vend_io_pkg:
  - State enum pd_state_t {PD_IDLE, PD_ON, PD_GAP}.
  - Constant MS_50M = 50_000.
- Sub-module ms_timer:
  - Inputs: CLK50M, RESET, restart, target.
  - Output: done.
  - Parameter CLK_PER_MS.
  - The same block serves other ms-delay needs in the design.

Test Plan (CLK_PER_MS=4, ON_MS=3, OFF_MS=2, PEND_W=2: ON=12 cycles, GAP=8 cycles, max pending 3):
- Single EVT at cycle 10 from IDLE -> Y=1 cycles 11..22, BUSY=1 cycles 11..30, IDLE at 31, PENDING stays 0.
- EVT at 10 and at 15 -> second pulse Y=1 cycles 31..42; PENDING=1 during 16..30, then 0.
- Five EVTs during the first pulse (cycles 12,13,14,15,16) -> PENDING reaches 3, OVF=1 at cycles 16 and 17 only; exactly 4 pulses emitted in total, each 12 high / 8 low.
- EVT at the exact cycle GAP done fires (cycle 30, PENDING=0) -> next ON starts at 31, PENDING stays 0, no IDLE cycle; also with PENDING=1, EVT on that same cycle -> PENDING stays 1.
- RESET asserted at cycle 17 mid-pulse with PENDING=2 -> Y=0, PENDING=0, BUSY=0 asynchronously; after release, no pulse until a new EVT arrives.
- Defaults (50 MHz): one EVT -> Y high for exactly 10_000_000 cycles, then BUSY for 5_000_000 more cycles.
